uncache_axi_ctrl: RTL and testbench
===================================

// Module: uncache_axi_ctrl
// PURPOSE
//  Sequences single uncached loads and stores from the memory-stage decoder onto an AXI3 master port.
//  Sits between the decoder's uncache_* request bus and the top-level AXI arbiter.
//  Accepts one request at a time and latches address, write data, strobe and size.
//  Drives exactly one AXI single-beat transaction per request, then returns read data or write completion to the pipeline.
// PARAMETERS
//  AXI_ID   4'd2   ARID/AWID driven on every transaction.
//  ID_W     4      Width of the AXI ID fields.
// PORTS
//  clk            in   1    Core clock; all state updates on the rising edge.
//  rst            in   1    Asynchronous reset, active high.
//  req_valid      in   1    Uncached request present (decoder uncache_valid).
//  req_op         in   1    1 = store, 0 = load.
//  req_tag        in   20   Physical tag; address = {req_tag, req_index, req_offset}.
//  req_index      in   8    Address bits [11:4].
//  req_offset     in   4    Address bits [3:0].
//  req_wstrb      in   4    Byte strobe, already lane-aligned.
//  req_wdata      in   32   Store data, already lane-aligned.
//  req_arsize     in   3    AXI size for loads.
//  req_awsize     in   3    AXI size for stores.
//  req_cancel     in   1    Pipeline flush: suppress the response of the outstanding request.
//  addr_ok        out  1    Request accepted this cycle.
//  data_ok        out  1    One-cycle pulse: load data valid, or store completed.
//  rdata_o        out  32   Load data; held until the next data_ok.
//  arid/araddr/arsize/arvalid   out  ID_W/32/3/1   AXI AR channel. arlen=0, arburst=INCR, arlock/cache/prot=0.
//  arready        in   1    AXI AR ready.
//  rdata/rvalid/rlast/rresp     in   32/1/1/2      AXI R channel.
//  rready         out  1    AXI R ready.
//  awid/awaddr/awsize/awvalid   out  ID_W/32/3/1   AXI AW channel. awlen=0, awburst=INCR.
//  awready        in   1    AXI AW ready.
//  wdata/wstrb/wvalid/wlast     out  32/4/1/1      AXI W channel. wid=AXI_ID, wlast=wvalid.
//  wready         in   1    AXI W ready.
//  bvalid         in   1    AXI B valid.
//  bready         out  1    AXI B ready.
// BEHAVIOUR
//  Reset:
//   - state=IDLE; every valid/ready output and data_ok = 0.
//   - rdata_o=0; latched address/data/strb/size = 0.
//   - Reset mid-transaction abandons it immediately. The AXI slave is reset by the same rst.
//  States: IDLE, AR, R, AW_W, B, DONE.
//  IDLE:
//   - addr_ok = req_valid (combinational).
//   - On req_valid, latch all req_* on the clock edge; cancel_q=0.
//   - req_op=0 -> AR; req_op=1 -> AW_W.
//  AR:
//   - arvalid=1 with latched addr/size; address and size are stable while arvalid=1.
//   - On arready -> R.
//  R:
//   - rready=1. On rvalid & rlast: rdata_o<=rdata (when not cancelled) -> DONE.
//   - rresp is ignored.
//  AW_W:
//   - awvalid and wvalid are both raised on entry.
//   - Each drops independently on its own handshake (aw_done/w_done flags).
//   - W may complete before, with, or after AW.
//   - Once both done -> B.
//  B:
//   - bready=1. On bvalid -> DONE.
//  DONE:
//   - data_ok = ~cancel_q for exactly one cycle -> IDLE.
//   - addr_ok=0 in DONE, so accepts are spaced at least one cycle apart.
//  req_cancel:
//   - In any non-IDLE state it sets cancel_q; cancel_q is sticky until IDLE.
//   - The AXI transaction always runs to completion.
//   - req_cancel in IDLE blocks acceptance: addr_ok=0 that cycle.
//  Address: {req_tag, req_index, req_offset}. It is not realigned; size and strobe come from the decoder as-is.
//  Minimum latency, load with arready and rvalid both at first opportunity:
//   accept T0; arvalid T1; rready T2; data_ok T3.
//  The same latency holds for a store (AW_W at T1, B at T2, data_ok at T3).
// TESTING
//  1. Load 0x1FAF_0004, size 2; arready and rvalid immediate, rdata=0xDEADBEEF -> araddr=0x1FAF0004, arsize=2, data_ok at T3, rdata_o=0xDEADBEEF.
//  2. Store 0x1FD0_0001, wstrb=4'b0010, wdata=0x0000AB00; wready 3 cycles before awready -> wvalid drops after W handshake, awvalid held until its handshake, exactly one B wait, data_ok once.
//  3. Load with arready stalled 5 cycles -> araddr and arsize stable and arvalid held for all 5 cycles, no second AR issued.
//  4. Load with req_cancel in state R -> R handshake completes, data_ok never asserted, rdata_o unchanged, next request accepted normally.
//  5. rst asserted in AW_W with awvalid high -> all outputs 0 asynchronously, state IDLE; next req_valid gets addr_ok=1.
//  6. Back-to-back load then store, req_valid held high -> second addr_ok only after DONE, no AXI overlap.

Source files
------------

// File: rtl/uncache_axi_ctrl.sv
// Uncached load/store sequencer: accepts one decoder request at a time and issues
// a single-beat AXI3 read or write for it, returning data or completion to the pipe.
module uncache_axi_ctrl #(
  parameter int unsigned       ID_W   = 4,
  parameter logic [ID_W-1:0]   AXI_ID = ID_W'(2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_op,
  input  logic [19:0]     req_tag,
  input  logic [7:0]      req_index,
  input  logic [3:0]      req_offset,
  input  logic [3:0]      req_wstrb,
  input  logic [31:0]     req_wdata,
  input  logic [2:0]      req_arsize,
  input  logic [2:0]      req_awsize,
  input  logic            req_cancel,
  output logic            addr_ok,
  output logic            data_ok,
  output logic [31:0]     rdata_o,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [31:0]     rdata,
  input  logic            rvalid,
  input  logic            rlast,
  input  logic [1:0]      rresp,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic            bvalid,
  output logic            bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_size;
  logic [31:0] r_rdata;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_cancel;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_r_last_hs;
  logic        w_cancel;
  logic        w_unused;

  assign w_aw_hs     = awvalid & awready;
  assign w_w_hs      = wvalid & wready;
  assign w_r_last_hs = rready & rvalid & rlast;
  // A flush arriving in the same cycle as the read beat must already block the capture.
  assign w_cancel    = r_cancel | req_cancel;
  assign w_unused    = ^rresp;

  // NOTE: state uses <= so every register samples pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_size    <= '0;
      r_rdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_cancel  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (addr_ok) begin
        r_addr    <= {req_tag, req_index, req_offset};
        r_wdata   <= req_wdata;
        r_wstrb   <= req_wstrb;
        r_size    <= req_op ? req_awsize : req_arsize;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_cancel  <= 1'b0;
      end else if (r_state != S_IDLE && req_cancel) begin
        r_cancel <= 1'b1;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_r_last_hs && !w_cancel) r_rdata <= rdata;
    end
  end

  // NOTE: defaults first so no path leaves an output unassigned (no latch).
  always_comb begin
    w_next  = r_state;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        addr_ok = req_valid & ~req_cancel;
        if (addr_ok) w_next = req_op ? S_AW_W : S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) w_next = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) w_next = S_DONE;
      end
      S_AW_W: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        if ((r_aw_done || awready) && (r_w_done || wready)) w_next = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) w_next = S_DONE;
      end
      S_DONE: begin
        data_ok = ~r_cancel;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign rdata_o = r_rdata;

  assign arid    = AXI_ID;
  assign araddr  = r_addr;
  assign arsize  = r_size;
  assign arlen   = 4'h0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'h0;

  assign awid    = AXI_ID;
  assign awaddr  = r_addr;
  assign awsize  = r_size;
  assign awlen   = 4'h0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'h0;
  assign awprot  = 3'h0;

  assign wid     = AXI_ID;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = wvalid;

endmodule

// File: tb/tb_uncache_axi_ctrl.sv
// Bench for uncache_axi_ctrl: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level model, all with a simple AXI slave.
module tb_uncache_axi_ctrl;
  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            req_valid, req_op, req_cancel;
  logic [19:0]     req_tag;
  logic [7:0]      req_index;
  logic [3:0]      req_offset, req_wstrb;
  logic [31:0]     req_wdata;
  logic [2:0]      req_arsize, req_awsize;
  logic            addr_ok, data_ok;
  logic [31:0]     rdata_o;
  logic [ID_W-1:0] arid, awid, wid;
  logic [31:0]     araddr, awaddr, wdata, rdata;
  logic [3:0]      arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, awburst, arlock, awlock, rresp;
  logic            arvalid, arready, rvalid, rlast, rready;
  logic            awvalid, awready, wvalid, wlast, wready, bvalid, bready;

  uncache_axi_ctrl #(.ID_W(ID_W), .AXI_ID(4'd2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_tag(req_tag), .req_index(req_index),
    .req_offset(req_offset), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .req_arsize(req_arsize), .req_awsize(req_awsize), .req_cancel(req_cancel),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata_o(rdata_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Slave knobs and bookkeeping
  int          ar_delay, r_delay, aw_delay, w_delay, b_delay;
  logic [31:0] r_value;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit          r_pend, b_pend, aw_got, w_got;
  bit          h_ar, h_r, h_aw, h_w, h_b;
  int          n_ar, n_r, n_aw, n_w, n_b, n_dok, n_arv, n_viol;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [3:0]  cap_arid, cap_awid, cap_wstrb;
  logic        cap_wlast;
  bit          p_ar_wait, p_aw_wait, p_w_wait;
  logic [31:0] p_araddr, p_awaddr, p_wdata;
  logic [2:0]  p_arsize, p_awsize;
  logic [3:0]  p_wstrb;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata_o;
  logic [31:0] exp_rdata;

  task automatic slave_reset();
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    p_ar_wait = 0; p_aw_wait = 0; p_w_wait = 0;
    arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 2'b00;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic clear_counts();
    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0; n_dok = 0; n_arv = 0;
  endtask

  // Mid-cycle snapshot of the DUT plus protocol monitoring.
  task automatic sample();
    s_addr_ok = addr_ok; s_data_ok = data_ok; s_rdata_o = rdata_o;
    h_ar = arvalid && arready; h_r = rvalid && rready && rlast;
    h_aw = awvalid && awready; h_w = wvalid && wready; h_b = bvalid && bready;
    if (int'(arvalid) + int'(rready) + int'(awvalid || wvalid) + int'(bready) > 1) n_viol++;
    if (p_ar_wait && (!arvalid || araddr != p_araddr || arsize != p_arsize)) n_viol++;
    if (p_aw_wait && (!awvalid || awaddr != p_awaddr || awsize != p_awsize)) n_viol++;
    if (p_w_wait && (!wvalid || wdata != p_wdata || wstrb != p_wstrb)) n_viol++;
    if (wvalid && !wlast) n_viol++;
    p_ar_wait = arvalid && !arready; p_araddr = araddr; p_arsize = arsize;
    p_aw_wait = awvalid && !awready; p_awaddr = awaddr; p_awsize = awsize;
    p_w_wait  = wvalid && !wready;   p_wdata  = wdata;  p_wstrb  = wstrb;
    if (arvalid) n_arv++;
    if (h_ar) begin n_ar++; cap_araddr = araddr; cap_arsize = arsize; cap_arid = arid; end
    if (h_aw) begin n_aw++; cap_awaddr = awaddr; cap_awsize = awsize; cap_awid = awid; end
    if (h_w)  begin n_w++;  cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast; end
    if (h_r) n_r++;
    if (h_b) n_b++;
    if (data_ok) n_dok++;
  endtask

  task automatic slave_update();
    if (h_ar) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; end
    if (h_r)  r_pend = 0;
    if (h_aw) begin aw_got = 1; aw_cnt = 0; end
    if (h_w)  begin w_got = 1; w_cnt = 0; end
    if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
    if (h_b)  b_pend = 0;
    arready = arvalid && (ar_cnt >= ar_delay);
    if (arvalid && !arready) ar_cnt++;
    awready = awvalid && (aw_cnt >= aw_delay);
    if (awvalid && !awready) aw_cnt++;
    wready = wvalid && (w_cnt >= w_delay);
    if (wvalid && !wready) w_cnt++;
    rvalid = r_pend && (r_cnt >= r_delay);
    rlast  = rvalid;
    rdata  = rvalid ? r_value : $urandom;
    rresp  = 2'($urandom);
    if (r_pend && !rvalid) r_cnt++;
    bvalid = b_pend && (b_cnt >= b_delay);
    if (b_pend && !bvalid) b_cnt++;
  endtask

  // One clock: snapshot mid-cycle, then let the slave react just after the edge.
  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    slave_update();
  endtask

  typedef struct {
    string       name;
    logic        op;
    logic [19:0] tag;
    logic [7:0]  idx;
    logic [3:0]  off;
    logic [2:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rval;
    int          ar_d, r_d, aw_d, w_d, b_d;
    logic [31:0] exp_addr;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic drive_req(input logic op, input logic [19:0] tag, input logic [7:0] idx,
                           input logic [3:0] off, input logic [2:0] size,
                           input logic [3:0] strb, input logic [31:0] wd);
    req_valid = 1; req_op = op; req_tag = tag; req_index = idx; req_offset = off;
    req_wstrb = strb; req_wdata = wd;
    req_arsize = op ? ~size : size;
    req_awsize = op ? size : ~size;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    clear_counts();
    ar_delay = v.ar_d; r_delay = v.r_d; aw_delay = v.aw_d; w_delay = v.w_d; b_delay = v.b_d;
    r_value = v.rval;
    drive_req(v.op, v.tag, v.idx, v.off, v.size, v.wstrb, v.wdata);
    cycle();
    check({v.name, " addr_ok"}, 32'(s_addr_ok), 32'd1);
    req_valid = 0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (s_data_ok) begin lat = k; break; end
    end
    cycle();
    cycle();
    check({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({v.name, " data_ok pulses"}, 32'(n_dok), 32'd1);
    check({v.name, " rdata_o"}, rdata_o, v.exp_rdata);
    check({v.name, " protocol"}, 32'(n_viol), 32'd0);
    if (!v.op) begin
      check({v.name, " araddr"}, cap_araddr, v.exp_addr);
      check({v.name, " arsize"}, 32'(cap_arsize), 32'(v.size));
      check({v.name, " arid"}, 32'(cap_arid), 32'd2);
      check({v.name, " ar/r/aw count"}, 32'(n_ar * 100 + n_r * 10 + n_aw), 32'd110);
      check({v.name, " arvalid cycles"}, 32'(n_arv), 32'(v.ar_d + 1));
    end else begin
      check({v.name, " awaddr"}, cap_awaddr, v.exp_addr);
      check({v.name, " awsize"}, 32'(cap_awsize), 32'(v.size));
      check({v.name, " awid"}, 32'(cap_awid), 32'd2);
      check({v.name, " wdata"}, cap_wdata, v.wdata);
      check({v.name, " wstrb/wlast"}, {27'd0, cap_wstrb, cap_wlast}, {27'd0, v.wstrb, 1'b1});
      check({v.name, " ar/aw/w/b count"}, 32'(n_ar * 1000 + n_aw * 100 + n_w * 10 + n_b), 32'd111);
    end
    exp_rdata = v.exp_rdata;
  endtask

  task automatic run_random(input int ncycles);
    bit          m_busy, m_resp, m_cancel, m_op, e_addr_ok, e_data_ok;
    logic [31:0] m_addr, m_wdata, m_rval;
    logic [2:0]  m_size;
    logic [3:0]  m_wstrb;
    int          m_nar, m_nr, m_naw, m_nw, m_nb;
    m_busy = 0; m_resp = 0; m_cancel = 0; m_op = 0;
    m_addr = '0; m_wdata = '0; m_rval = '0; m_size = '0; m_wstrb = '0;
    m_nar = 0; m_nr = 0; m_naw = 0; m_nw = 0; m_nb = 0;
    for (int c = 0; c < ncycles + 60; c++) begin
      if (c >= ncycles && !m_busy) break;
      if (c < ncycles) begin
        drive_req(1'($urandom), 20'($urandom), 8'($urandom), 4'($urandom),
                  3'($urandom_range(0, 2)), 4'($urandom), $urandom);
        req_valid  = ($urandom_range(0, 2) != 0);
        req_cancel = ($urandom_range(0, 11) == 0);
      end else begin
        req_valid = 0; req_cancel = 0;
      end
      e_addr_ok = !m_busy && req_valid && !req_cancel;
      e_data_ok = m_resp && !m_cancel;
      if (e_addr_ok) begin
        m_op = req_op; m_addr = {req_tag, req_index, req_offset};
        m_size = req_op ? req_awsize : req_arsize;
        m_wdata = req_wdata; m_wstrb = req_wstrb;
        ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
        aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
        b_delay = $urandom_range(0, 3); r_value = $urandom; m_rval = r_value;
      end
      cycle();
      check("rnd addr_ok", 32'(s_addr_ok), 32'(e_addr_ok));
      check("rnd data_ok", 32'(s_data_ok), 32'(e_data_ok));
      check("rnd rdata_o", s_rdata_o, exp_rdata);
      if (h_ar) begin
        m_nar++;
        check("rnd ar addr", cap_araddr, m_addr);
        check("rnd ar size", 32'(cap_arsize), 32'(m_size));
      end
      if (h_aw) begin
        m_naw++;
        check("rnd aw addr", cap_awaddr, m_addr);
        check("rnd aw size", 32'(cap_awsize), 32'(m_size));
      end
      if (h_w) begin
        m_nw++;
        check("rnd w data", cap_wdata, m_wdata);
        check("rnd w strb", 32'(cap_wstrb), 32'(m_wstrb));
      end
      if (h_r) m_nr++;
      if (h_b) m_nb++;
      if (m_resp) begin
        check("rnd read beats", 32'(m_nar + m_nr), m_op ? 32'd0 : 32'd2);
        check("rnd write beats", 32'(m_naw + m_nw + m_nb), m_op ? 32'd3 : 32'd0);
        m_busy = 0; m_resp = 0;
      end else if (m_busy) begin
        if (req_cancel) m_cancel = 1;
        if (h_r) begin
          m_resp = 1;
          if (!m_cancel) exp_rdata = m_rval;
        end
        if (h_b) m_resp = 1;
      end
      if (e_addr_ok) begin
        m_busy = 1; m_cancel = 0;
        m_nar = 0; m_nr = 0; m_naw = 0; m_nw = 0; m_nb = 0;
      end
    end
    check("rnd drained", 32'(m_busy), 32'd0);
    check("rnd protocol", 32'(n_viol), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat;
    vecs[0] = '{"load_basic", 1'b0, 20'h1FAF0, 8'h00, 4'h4, 3'd2, 4'h0, 32'h0,
                32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h1FAF0004, 3, 32'hDEADBEEF};
    vecs[1] = '{"store_w_first", 1'b1, 20'h1FD00, 8'h00, 4'h1, 3'd0, 4'b0010, 32'h0000AB00,
                32'h0, 0, 0, 3, 0, 0, 32'h1FD00001, 6, 32'hDEADBEEF};
    vecs[2] = '{"load_ar_stall", 1'b0, 20'h12345, 8'h67, 4'h8, 3'd1, 4'h0, 32'h0,
                32'hCAFEF00D, 5, 0, 0, 0, 0, 32'h12345678, 8, 32'hCAFEF00D};
    vecs[3] = '{"store_aw_first", 1'b1, 20'hABCDE, 8'hF0, 4'hC, 3'd1, 4'b1100, 32'h5A5A0000,
                32'h0, 0, 0, 0, 2, 2, 32'hABCDEF0C, 7, 32'hCAFEF00D};
    vecs[4] = '{"store_together", 1'b1, 20'h00010, 8'h20, 4'h3, 3'd0, 4'b1000, 32'h77000000,
                32'h0, 0, 0, 1, 1, 0, 32'h00010203, 4, 32'hCAFEF00D};
    vecs[5] = '{"load_r_stall", 1'b0, 20'h80000, 8'hFF, 4'h0, 3'd2, 4'h0, 32'h0,
                32'h13579BDF, 0, 3, 0, 0, 0, 32'h80000FF0, 6, 32'h13579BDF};

    req_valid = 0; req_op = 0; req_cancel = 0; req_tag = '0; req_index = '0;
    req_offset = '0; req_wstrb = '0; req_wdata = '0; req_arsize = '0; req_awsize = '0;
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0; r_value = '0;
    n_viol = 0; exp_rdata = '0;
    slave_reset();
    clear_counts();
    rst = 1;
    #12;
    check("reset handshakes", {25'd0, arvalid, rready, awvalid, wvalid, bready, data_ok, addr_ok}, 32'd0);
    check("reset rdata_o", rdata_o, 32'd0);
    check("reset araddr", araddr, 32'd0);
    check("reset wdata/wstrb", wdata ^ {28'd0, wstrb}, 32'd0);
    check("const ar fields", {17'd0, arlen, arburst, arlock, arcache, arprot},
          {17'd0, 4'h0, 2'b01, 2'b00, 4'h0, 3'h0});
    check("const aw fields", {17'd0, awlen, awburst, awlock, awcache, awprot},
          {17'd0, 4'h0, 2'b01, 2'b00, 4'h0, 3'h0});
    check("const ids", {20'd0, arid, awid, wid}, {20'd0, 4'd2, 4'd2, 4'd2});
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Cancel while idle must block acceptance and issue nothing.
    clear_counts();
    ar_delay = 0; r_delay = 3; aw_delay = 0; w_delay = 0; b_delay = 0; r_value = 32'h55AA55AA;
    drive_req(1'b0, 20'h0CAFE, 8'h11, 4'h4, 3'd2, 4'h0, 32'h0);
    req_cancel = 1;
    cycle();
    check("idle cancel addr_ok", 32'(s_addr_ok), 32'd0);
    req_valid = 0; req_cancel = 0;
    cycle();
    cycle();
    check("idle cancel no AR", 32'(n_ar), 32'd0);

    // Flush while waiting in R: the read completes but is never reported.
    req_valid = 1;
    cycle();
    check("cancel_r addr_ok", 32'(s_addr_ok), 32'd1);
    req_valid = 0;
    cycle();
    req_cancel = 1;
    cycle();
    req_cancel = 0;
    for (int k = 0; k < 10; k++) cycle();
    check("cancel_r read done", 32'(n_r), 32'd1);
    check("cancel_r no data_ok", 32'(n_dok), 32'd0);
    check("cancel_r rdata_o held", rdata_o, exp_rdata);
    v = '{"after_cancel", 1'b0, 20'h00AAA, 8'h55, 4'h0, 3'd2, 4'h0, 32'h0,
          32'h0BADF00D, 1, 1, 0, 0, 0, 32'h00AAA550, 5, 32'h0BADF00D};
    run_vec(v);

    // Asynchronous reset while AW/W are outstanding.
    clear_counts();
    aw_delay = 10; w_delay = 10;
    drive_req(1'b1, 20'h44444, 8'h44, 4'h4, 3'd2, 4'hF, 32'h99999999);
    cycle();
    req_valid = 0;
    check("pre-reset awvalid", {30'd0, awvalid, wvalid}, 32'd3);
    #2;
    rst = 1;
    #1;
    check("async reset handshakes", {25'd0, arvalid, rready, awvalid, wvalid, bready, data_ok, addr_ok}, 32'd0);
    check("async reset awaddr", awaddr, 32'd0);
    check("async reset rdata_o", rdata_o, 32'd0);
    exp_rdata = '0;
    slave_reset();
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    v = '{"after_reset", 1'b0, 20'h31415, 8'h92, 4'h4, 3'd2, 4'h0, 32'h0,
          32'h27182818, 0, 0, 0, 0, 0, 32'h31415924, 3, 32'h27182818};
    run_vec(v);

    // Back-to-back: load then store with req_valid held high throughout.
    clear_counts();
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0; r_value = 32'h2468ACE0;
    drive_req(1'b0, 20'h00ABC, 8'h12, 4'h0, 3'd2, 4'h0, 32'h0);
    cycle();
    check("b2b first addr_ok", 32'(s_addr_ok), 32'd1);
    drive_req(1'b1, 20'h00DEF, 8'h34, 4'h0, 3'd2, 4'hF, 32'h11223344);
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check($sformatf("b2b addr_ok T%0d", k), 32'(s_addr_ok), 32'(k == 4));
      if (k == 3) check("b2b load data_ok", 32'(s_data_ok), 32'd1);
    end
    req_valid = 0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (s_data_ok) begin lat = k; break; end
    end
    check("b2b store latency", 32'(lat), 32'd3);
    check("b2b ar/aw count", 32'(n_ar * 10 + n_aw), 32'd11);
    check("b2b data_ok pulses", 32'(n_dok), 32'd2);
    check("b2b awaddr", cap_awaddr, 32'h00DEF340);
    check("b2b rdata_o", rdata_o, 32'h2468ACE0);
    check("b2b protocol", 32'(n_viol), 32'd0);
    exp_rdata = 32'h2468ACE0;

    run_random(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
